// File: rtl/mem_req_arbiter_if.sv
// SRAM-like request/response channel: master issues commands, slave answers.
// Used for the fetch port, the data port and the shared memory bus.
interface mem_req_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Fetch/data arbiter for one shared memory bus, one transaction in flight,
// data-first priority with a starvation bound for fetch and flush cancel.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_en,
    mem_req_arbiter_if.slave  inst_if,
    mem_req_arbiter_if.slave  data_if,
    mem_req_arbiter_if.master bus_if
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wr_q, wr_d;
    logic [1:0]    size_q, size_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          cancel_q, cancel_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          kill;
    logic          pick_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            wstrb_q  <= 4'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            cancel_q <= 1'b0;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            wstrb_q  <= wstrb_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cancel_q <= cancel_d;
            streak_q <= streak_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        size_d   = size_q;
        wstrb_d  = wstrb_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cancel_d = cancel_q;
        streak_d = streak_q;

        bus_if.req      = 1'b0;
        bus_if.wr       = 1'b0;
        bus_if.size     = 2'd0;
        bus_if.wstrb    = 4'd0;
        bus_if.addr     = 32'd0;
        bus_if.wdata    = 32'd0;
        inst_if.addr_ok = 1'b0;
        inst_if.data_ok = 1'b0;
        inst_if.rdata   = 32'd0;
        data_if.addr_ok = 1'b0;
        data_if.data_ok = 1'b0;
        data_if.rdata   = 32'd0;

        // a flush landing this very cycle must already hide the fetch result
        kill      = cancel_q | ex_en;
        pick_data = data_if.req && !(inst_if.req && streak_q == LIMIT);

        unique case (state_q)
            IDLE: begin
                cancel_d = 1'b0;
                if (pick_data) begin
                    state_d  = ADDR;
                    owner_d  = 1'b1;
                    wr_d     = data_if.wr;
                    size_d   = data_if.size;
                    wstrb_d  = data_if.wstrb;
                    addr_d   = data_if.addr;
                    wdata_d  = data_if.wdata;
                    if (!inst_if.req)
                        streak_d = '0;
                    else if (streak_q != LIMIT)
                        streak_d = streak_q + SW'(1);
                end else if (inst_if.req) begin
                    state_d  = ADDR;
                    owner_d  = 1'b0;
                    wr_d     = 1'b0;
                    size_d   = 2'd2;
                    wstrb_d  = 4'd0;
                    addr_d   = inst_if.addr;
                    wdata_d  = 32'd0;
                    streak_d = '0;
                end
            end
            ADDR: begin
                bus_if.req   = 1'b1;
                bus_if.wr    = wr_q;
                bus_if.size  = size_q;
                bus_if.wstrb = wstrb_q;
                bus_if.addr  = addr_q;
                bus_if.wdata = wdata_q;
                if (ex_en && !owner_q)
                    cancel_d = 1'b1;
                if (bus_if.addr_ok) begin
                    state_d = RESP;
                    if (owner_q)
                        data_if.addr_ok = 1'b1;
                    else
                        inst_if.addr_ok = !kill;
                end
            end
            RESP: begin
                if (ex_en && !owner_q)
                    cancel_d = 1'b1;
                if (bus_if.data_ok) begin
                    state_d  = IDLE;
                    cancel_d = 1'b0;
                    if (owner_q) begin
                        data_if.data_ok = 1'b1;
                        data_if.rdata   = bus_if.rdata;
                    end else if (!kill) begin
                        inst_if.data_ok = 1'b1;
                        inst_if.rdata   = bus_if.rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: per-cycle vector table plus
// hand-written contention, flush-in-ADDR and async-reset sequences.
module tb_mem_req_arbiter;
    logic clk;
    logic rst;
    logic ex_en;

    mem_req_arbiter_if u_inst ();
    mem_req_arbiter_if u_data ();
    mem_req_arbiter_if u_bus ();

    mem_req_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .ex_en   (ex_en),
        .inst_if (u_inst),
        .data_if (u_data),
        .bus_if  (u_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [1:0]  ds;
        logic [3:0]  dst;
        logic [31:0] da;
        logic [31:0] dwd;
        logic        ex;
        logic        baok;
        logic        bdok;
        logic [31:0] brd;
    } vin_t;

    typedef struct {
        vin_t         i;
        logic [139:0] e;
    } vec_t;

    vec_t tbl[$];
    int   n_chk;
    int   n_fail;

    function automatic vin_t vin(logic ir, logic [31:0] ia, logic dr,
                                 logic dw, logic [1:0] ds, logic [3:0] dst,
                                 logic [31:0] da, logic [31:0] dwd,
                                 logic ex, logic baok, logic bdok,
                                 logic [31:0] brd);
        vin_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.ds = ds;
        v.dst = dst; v.da = da; v.dwd = dwd; v.ex = ex;
        v.baok = baok; v.bdok = bdok; v.brd = brd;
        return v;
    endfunction

    // {breq,bwr,bsize,bstrb,baddr,bwdata,iaok,idok,irdata,daok,ddok,drdata}
    function automatic logic [139:0] pk(logic breq, logic bwr,
                                        logic [1:0] bsz, logic [3:0] bst,
                                        logic [31:0] badr, logic [31:0] bwd,
                                        logic iaok, logic idok,
                                        logic [31:0] ird, logic daok,
                                        logic ddok, logic [31:0] drd);
        return {breq, bwr, bsz, bst, badr, bwd, iaok, idok, ird,
                daok, ddok, drd};
    endfunction

    function automatic logic [139:0] ex_addr(logic bwr, logic [1:0] bsz,
                                             logic [3:0] bst,
                                             logic [31:0] badr,
                                             logic [31:0] bwd,
                                             logic iaok, logic daok);
        return pk(1'b1, bwr, bsz, bst, badr, bwd, iaok, 1'b0, 32'd0,
                  daok, 1'b0, 32'd0);
    endfunction

    function automatic logic [139:0] ex_di(logic [31:0] rd);
        return pk(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1, rd,
                  1'b0, 1'b0, 32'd0);
    endfunction

    function automatic logic [139:0] ex_dd(logic [31:0] rd);
        return pk(1'b0, 1'b0, 2'd0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0,
                  1'b0, 1'b1, rd);
    endfunction

    function automatic logic [139:0] dut_out();
        return pk(u_bus.req, u_bus.wr, u_bus.size, u_bus.wstrb, u_bus.addr,
                  u_bus.wdata, u_inst.addr_ok, u_inst.data_ok, u_inst.rdata,
                  u_data.addr_ok, u_data.data_ok, u_data.rdata);
    endfunction

    task automatic apply(input vin_t v);
        u_inst.req    = v.ir;
        u_inst.addr   = v.ia;
        u_data.req    = v.dr;
        u_data.wr     = v.dw;
        u_data.size   = v.ds;
        u_data.wstrb  = v.dst;
        u_data.addr   = v.da;
        u_data.wdata  = v.dwd;
        ex_en         = v.ex;
        u_bus.addr_ok = v.baok;
        u_bus.data_ok = v.bdok;
        u_bus.rdata   = v.brd;
    endtask

    task automatic chk(input string nm, input logic [139:0] exp);
        logic [139:0] got;
        got = dut_out();
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] L  = 32'h1c000100;
    localparam logic [31:0] S  = 32'h1c000200;
    localparam logic [31:0] F  = 32'h1c000000;
    localparam logic [31:0] D3 = 32'h1c000300;
    localparam logic [31:0] F1 = 32'h1c000010;
    localparam logic [31:0] F2 = 32'h1c000020;
    localparam logic [31:0] IA = 32'h1c001000;
    localparam logic [31:0] DA = 32'h1c002000;
    localparam logic [31:0] FA = 32'h1c003000;
    localparam logic [31:0] AR = 32'h1c004000;
    localparam logic [31:0] AR2 = 32'h1c005000;

    vin_t z;
    int   streak_m;
    logic exp_inst;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        z = vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // lone load
        tbl.push_back('{vin(0,0,1,0,2,0,L,0,0,0,0,0), '0});
        tbl.push_back('{vin(0,0,1,0,2,0,L,0,0,1,0,0),
                        ex_addr(0,2,0,L,0,0,1)});
        tbl.push_back('{vin(0,0,0,0,2,0,L,0,0,0,1,32'hdeadbeef),
                        ex_dd(32'hdeadbeef)});
        tbl.push_back('{z, '0});
        // store, inputs change after grant
        tbl.push_back('{vin(0,0,1,1,0,4'b0100,S,32'h00aa0000,0,0,0,0), '0});
        tbl.push_back('{vin(0,0,1,0,2,4'hf,0,32'hffffffff,0,0,0,0),
                        ex_addr(1,0,4'b0100,S,32'h00aa0000,0,0)});
        tbl.push_back('{vin(0,0,1,0,2,4'hf,0,32'hffffffff,0,1,0,0),
                        ex_addr(1,0,4'b0100,S,32'h00aa0000,0,1)});
        tbl.push_back('{vin(0,0,0,0,0,0,0,0,0,0,1,32'h11223344),
                        ex_dd(32'h11223344)});
        // fetch flushed in RESP, pending load follows
        tbl.push_back('{vin(1,F,0,0,0,0,0,0,0,0,0,0), '0});
        tbl.push_back('{vin(1,F,1,0,2,0,D3,0,0,1,0,0),
                        ex_addr(0,2,0,F,0,1,0)});
        tbl.push_back('{vin(0,0,1,0,2,0,D3,0,1,0,0,0), '0});
        tbl.push_back('{vin(0,0,1,0,2,0,D3,0,0,0,1,32'h12345678), '0});
        tbl.push_back('{vin(0,0,1,0,2,0,D3,0,0,0,0,0), '0});
        tbl.push_back('{vin(0,0,1,0,2,0,D3,0,0,1,0,0),
                        ex_addr(0,2,0,D3,0,0,1)});
        tbl.push_back('{vin(0,0,0,0,0,0,0,0,0,0,1,32'hcafef00d),
                        ex_dd(32'hcafef00d)});
        tbl.push_back('{z, '0});
        // flush coinciding with bus data_ok
        tbl.push_back('{vin(1,F1,0,0,0,0,0,0,0,0,0,0), '0});
        tbl.push_back('{vin(1,F1,0,0,0,0,0,0,0,1,0,0),
                        ex_addr(0,2,0,F1,0,1,0)});
        tbl.push_back('{vin(0,0,0,0,0,0,0,0,1,0,1,32'h55555555), '0});
        tbl.push_back('{z, '0});
        // ex_en in IDLE is ignored, fetch data returns
        tbl.push_back('{vin(1,F2,0,0,0,0,0,0,1,0,0,0), '0});
        tbl.push_back('{vin(1,F2,0,0,0,0,0,0,0,1,0,0),
                        ex_addr(0,2,0,F2,0,1,0)});
        tbl.push_back('{vin(0,0,0,0,0,0,0,0,0,0,1,32'h0badf00d),
                        ex_di(32'h0badf00d)});
        tbl.push_back('{z, '0});

        u_inst.wr = 1'b0;
        u_inst.size = 2'd0;
        u_inst.wstrb = 4'd0;
        u_inst.wdata = 32'd0;
        apply(z);
        rst = 1'b1;
        #3;
        chk("reset_outputs", '0);
        #9;
        rst = 1'b0;
        step();

        foreach (tbl[k]) begin
            apply(tbl[k].i);
            #2;
            chk($sformatf("vec%0d", k), tbl[k].e);
            step();
        end

        // contention, zero-wait bus
        streak_m = 0;
        for (int t = 0; t < 10; t++) begin
            apply(vin(1,IA,1,0,2,0,DA,0,0,0,0,0));
            step();
            exp_inst = (streak_m == 4);
            streak_m = exp_inst ? 0 : streak_m + 1;
            apply(vin(1,IA,1,0,2,0,DA,0,0,1,0,0));
            #2;
            chk($sformatf("cont_grant%0d", t),
                exp_inst ? ex_addr(0,2,0,IA,0,1,0)
                         : ex_addr(0,2,0,DA,0,0,1));
            step();
            apply(vin(1,IA,1,0,2,0,DA,0,0,0,1,32'(t + 100)));
            #2;
            chk($sformatf("cont_resp%0d", t),
                exp_inst ? ex_di(32'(t + 100)) : ex_dd(32'(t + 100)));
            step();
        end

        // flush in ADDR with addr_ok delayed three cycles
        apply(vin(1,FA,0,0,0,0,0,0,0,0,0,0));
        #2;
        chk("fa_idle", '0);
        step();
        apply(vin(1,FA,0,0,0,0,0,0,1,0,0,0));
        #2;
        chk("fa_wait0", ex_addr(0,2,0,FA,0,0,0));
        step();
        for (int w = 1; w < 3; w++) begin
            apply(z);
            #2;
            chk($sformatf("fa_wait%0d", w), ex_addr(0,2,0,FA,0,0,0));
            step();
        end
        apply(vin(0,0,0,0,0,0,0,0,0,1,0,0));
        #2;
        chk("fa_addr_ok", ex_addr(0,2,0,FA,0,0,0));
        step();
        apply(vin(0,0,0,0,0,0,0,0,0,0,1,32'h77777777));
        #2;
        chk("fa_data_ok", '0);
        step();
        apply(vin(0,0,0,0,0,0,0,0,0,1,0,0));
        #2;
        chk("fa_idle_after", '0);
        step();

        // async reset while RESP is signalling data_ok
        apply(vin(0,0,1,0,2,0,AR,0,0,0,0,0));
        step();
        apply(vin(0,0,1,0,2,0,AR,0,0,1,0,0));
        #2;
        chk("ar_addr", ex_addr(0,2,0,AR,0,0,1));
        step();
        apply(vin(0,0,0,0,0,0,0,0,0,0,1,32'ha5a5a5a5));
        #2;
        chk("ar_before", ex_dd(32'ha5a5a5a5));
        #1;
        rst = 1'b1;
        #1;
        chk("ar_async", '0);
        #2;
        rst = 1'b0;
        apply(vin(0,0,1,0,2,0,AR2,0,0,0,0,0));
        #1;
        chk("ar_idle", '0);
        step();
        apply(vin(0,0,1,0,2,0,AR2,0,0,1,0,0));
        #2;
        chk("ar_min_addr", ex_addr(0,2,0,AR2,0,0,1));
        step();
        apply(vin(0,0,0,0,0,0,0,0,0,0,1,32'h600dcafe));
        #2;
        chk("ar_min_data", ex_dd(32'h600dcafe));
        step();
        apply(z);
        #2;
        chk("ar_end_idle", '0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
